// File: rtl/aes_inv_main.sv
// Iterative AES-128 inverse cipher (FIPS-197 InvCipher), one round per clock.
// The key schedule is run forward to round key 10, then stepped back one round per cycle.

package aes_inv_main_pkg;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

endpackage

module aes_sbox
    import aes_inv_main_pkg::*;
(
    input  logic [7:0] i_x,
    output logic [7:0] o_y
);
    logic [7:0] w_inv;

    assign w_inv = gf_inv(i_x);
    assign o_y   = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                 ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

module aes_inv_sbox
    import aes_inv_main_pkg::*;
(
    input  logic [7:0] i_x,
    output logic [7:0] o_y
);
    logic [7:0] w_pre;

    assign w_pre = {i_x[6:0], i_x[7]} ^ {i_x[4:0], i_x[7:5]} ^ {i_x[1:0], i_x[7:2]} ^ 8'h05;
    assign o_y   = gf_inv(w_pre);
endmodule

module aes_inv_main
    import aes_inv_main_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext
);
    localparam int unsigned BLK_W = 128;
    localparam int unsigned RND_W = 4;

    typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL, DONE} state_e;

    state_e             r_state, w_state_d;
    logic [BLK_W-1:0]   r_ct, r_key, r_blk;
    logic [BLK_W-1:0]   w_ct_d, w_key_d, w_blk_d;
    logic [RND_W-1:0]   r_rnd, w_rnd_d;
    logic               r_in_ready, r_out_valid;

    logic [7:0]         w_rcon;
    logic [31:0]        w_sw_in, w_rot, w_sw_out, w_t;
    logic [31:0]        w_k0, w_k1, w_k2, w_k3, w_f0, w_f1, w_f2, w_f3;
    logic [BLK_W-1:0]   w_key_fwd, w_key_inv;
    logic [BLK_W-1:0]   w_sr, w_isb, w_ark, w_imc;

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // r_rnd holds the Rcon index for both the forward and the backward key step
    always_comb begin
        w_rcon = 8'h00;
        case (r_rnd)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // Shared SubWord: forward step uses old w3, backward step uses the recovered w3
    assign {w_k0, w_k1, w_k2, w_k3} = r_key;
    assign w_sw_in = (r_state == KEYEXP) ? w_k3 : (w_k3 ^ w_k2);
    assign w_rot   = {w_sw_in[23:0], w_sw_in[31:24]};
    assign w_t     = w_sw_out ^ {w_rcon, 24'h000000};

    for (genvar g = 0; g < 4; g++) begin : g_sw
        aes_sbox u_sbox (.i_x(w_rot[8*g +: 8]), .o_y(w_sw_out[8*g +: 8]));
    end

    assign w_f0      = w_k0 ^ w_t;
    assign w_f1      = w_k1 ^ w_f0;
    assign w_f2      = w_k2 ^ w_f1;
    assign w_f3      = w_k3 ^ w_f2;
    assign w_key_fwd = {w_f0, w_f1, w_f2, w_f3};
    assign w_key_inv = {w_k0 ^ w_t, w_k1 ^ w_k0, w_k2 ^ w_k1, w_k3 ^ w_k2};

    // InvShiftRows: row r of column c comes from column (c - r) mod 4
    always_comb begin
        w_sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[8*(15-(4*c+r)) +: 8] = r_blk[8*(15-(4*((c+4-r)%4)+r)) +: 8];
            end
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_isb
        aes_inv_sbox u_inv_sbox (.i_x(w_sr[8*g +: 8]), .o_y(w_isb[8*g +: 8]));
    end

    assign w_ark = w_isb ^ r_key;
    assign w_imc = {inv_mix_col(w_ark[127:96]), inv_mix_col(w_ark[95:64]),
                    inv_mix_col(w_ark[63:32]),  inv_mix_col(w_ark[31:0])};

    always_comb begin
        w_state_d = r_state;
        w_ct_d    = r_ct;
        w_key_d   = r_key;
        w_blk_d   = r_blk;
        w_rnd_d   = r_rnd;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_d = KEYEXP;
                    w_ct_d    = ciphertext;
                    w_key_d   = key;
                    w_rnd_d   = RND_W'(1);
                end
            end
            KEYEXP: begin
                w_key_d = w_key_fwd;
                if (r_rnd == RND_W'(10)) w_state_d = INIT;
                else                     w_rnd_d   = r_rnd + RND_W'(1);
            end
            INIT: begin
                w_blk_d   = r_ct ^ r_key;
                w_key_d   = w_key_inv;
                w_rnd_d   = RND_W'(9);
                w_state_d = ROUND;
            end
            ROUND: begin
                w_blk_d = w_imc;
                w_key_d = w_key_inv;
                w_rnd_d = r_rnd - RND_W'(1);
                if (r_rnd == RND_W'(1)) w_state_d = FINAL;
            end
            FINAL: begin
                w_blk_d   = w_ark;
                w_key_d   = '0;
                w_ct_d    = '0;
                w_state_d = DONE;
            end
            DONE: begin
                if (out_ready) w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ct        <= '0;
            r_key       <= '0;
            r_blk       <= '0;
            r_rnd       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_ct        <= w_ct_d;
            r_key       <= w_key_d;
            r_blk       <= w_blk_d;
            r_rnd       <= w_rnd_d;
            r_in_ready  <= (w_state_d == IDLE);
            r_out_valid <= (w_state_d == DONE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign plaintext = r_blk;

endmodule

// File: tb/tb_aes_inv_main.sv
// Directed and round-trip checks for aes_inv_main against FIPS-197 vectors and a forward-cipher model.

module tb_aes_inv_main;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] sbox [256];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    always #5 clk = ~clk;

    aes_inv_main dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ciphertext(ciphertext),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .plaintext (plaintext)
    );

    // ---------------- forward-cipher reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] aa;
        logic [7:0] bb;
        r = 8'h00; aa = a; bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) r = r ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox[x] = s;
        end
    endtask

    function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox[w3[23:16]] ^ rc, sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] enc(input logic [127:0] p, input logic [127:0] k);
        logic [127:0] s, t, rk;
        logic [7:0]   rc, a0, a1, a2, a3;
        rk = k;
        s  = p ^ rk;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            rk = next_rk(rk, rc);
            rc = xt(rc);
            for (int b = 0; b < 16; b++) t[8*(15-b) +: 8] = sbox[s[8*(15-b) +: 8]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    s[8*(15-(4*c+w)) +: 8] = t[8*(15-(4*((c+w)%4)+w)) +: 8];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    {a0, a1, a2, a3} = s[8*(15-4*c)-24 +: 32];
                    s[8*(15-4*c)-24 +: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                             a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                             a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                             xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
                end
            end
            s = s ^ rk;
        end
        return s;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Accepts one block and reports plaintext plus the edge count (acceptance = edge 0) to out_valid.
    task automatic run_block(input logic [127:0] ct, input logic [127:0] k, input bit scramble,
                             output logic [127:0] pt, output int lat);
        int waited;
        lat = -1;
        pt  = '0;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
            return;
        end
        ciphertext = ct;
        key        = k;
        in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (scramble) begin
            ciphertext = ~ct;
            key        = k ^ 128'hdeadbeef_cafef00d_01234567_89abcdef;
        end else begin
            in_valid = 1'b0;
        end
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 15) in_valid = 1'b0;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        in_valid = 1'b0;
        if (lat < 0) begin
            n_vec++; n_err++;
            $display("FAIL out_valid_timeout: out_valid=%b required 1 within 40 edges", out_valid);
            return;
        end
        pt = plaintext;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        ciphertext = C1_CT; key = C1_KEY;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        n_vec++; if (plaintext !== 128'h0) begin n_err++; $display("FAIL reset_plaintext: got %h required 0", plaintext); end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_no_accept: in_ready=%b required 1", in_ready); end
    endtask

    task automatic test_c1_ready_early();
        logic [127:0] pt;
        int lat;
        out_ready = 1'b1;
        run_block(C1_CT, C1_KEY, 1'b0, pt, lat);
        if (lat > 0) begin
            n_vec++; if (lat != 21) begin n_err++; $display("FAIL c1_latency: got %0d required 21", lat); end
            n_vec++; if (pt !== C1_PT) begin n_err++; $display("FAIL c1_plaintext: got %h required %h", pt, C1_PT); end
            @(posedge clk);
            #1;
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL c1_one_cycle_valid: out_valid=%b required 0", out_valid); end
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL c1_back_idle: in_ready=%b required 1", in_ready); end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] pt;
        int lat;
        out_ready = 1'b0;
        run_block(B_CT, B_KEY, 1'b0, pt, lat);
        if (lat > 0) begin
            n_vec++; if (lat != 21) begin n_err++; $display("FAIL b_latency: got %0d required 21", lat); end
            n_vec++; if (pt !== B_PT) begin n_err++; $display("FAIL b_plaintext: got %h required %h", pt, B_PT); end
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                n_vec++;
                if (out_valid !== 1'b1 || plaintext !== B_PT || in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL hold_cycle%0d: valid=%b ready=%b pt=%h required valid=1 ready=0 pt=%h",
                             i, out_valid, in_ready, plaintext, B_PT);
                end
            end
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b required 0", out_valid); end
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b required 1", in_ready); end
        end
    endtask

    task automatic test_input_hold();
        logic [127:0] pt;
        int lat;
        out_ready = 1'b1;
        run_block(C1_CT, C1_KEY, 1'b1, pt, lat);
        if (lat > 0) begin
            n_vec++; if (lat != 21) begin n_err++; $display("FAIL hold_latency: got %0d required 21", lat); end
            n_vec++; if (pt !== C1_PT) begin n_err++; $display("FAIL hold_plaintext: got %h required %h", pt, C1_PT); end
        end
    endtask

    task automatic test_reset_midop();
        logic [127:0] pt;
        int lat;
        bit seen;
        out_ready = 1'b1;
        @(negedge clk);
        ciphertext = B_CT; key = B_KEY; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (13) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b required 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b required 1", in_ready); end
        n_vec++; if (plaintext !== 128'h0) begin n_err++; $display("FAIL midrst_plaintext: got %h required 0", plaintext); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        n_vec++; if (seen) begin n_err++; $display("FAIL midrst_no_output: out_valid seen=1 required 0"); end
        run_block(B_CT, B_KEY, 1'b0, pt, lat);
        if (lat > 0) begin
            n_vec++; if (pt !== B_PT) begin n_err++; $display("FAIL midrst_next_block: got %h required %h", pt, B_PT); end
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] p, k, c, pt;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            c = enc(p, k);
            run_block(c, k, 1'b0, pt, lat);
            if (lat > 0) begin
                n_vec++;
                if (pt !== p || lat != 21) begin
                    n_err++;
                    $display("FAIL roundtrip%0d: got %h lat %0d required %h lat 21", i, pt, lat, p);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ciphertext = '0; key = '0;
        build_sbox();
        test_reset();
        test_c1_ready_early();
        test_backpressure();
        test_input_hold();
        test_reset_midop();
        test_round_trip();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_inv_main.md
AES_INV_MAIN -- requirements
Module: aes_inv_main

Interface
REQ-001 The module SHALL have no parameters; AES-128 only (Nk=4, Nr=10).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  ciphertext and key valid.
REQ-005 in_ready  output  1  block can accept a new ciphertext/key pair.
REQ-006 ciphertext  input  128  cipher block; bit 127 = FIPS-197 byte 0 MSB.
REQ-007 key  input  128  cipher key; same byte ordering as ciphertext.
REQ-008 out_valid  output  1  plaintext holds a completed result.
REQ-009 out_ready  input  1  consumer accepts plaintext.
REQ-010 plaintext  output  128  decrypted block; same byte ordering.

Function
REQ-011 The block SHALL be iterative, one round per clock, and SHALL be the inverse-cipher counterpart of aes_main (FIPS-197 InvCipher).
REQ-012 Input handshake: transfer occurs on a rising edge with in_valid && in_ready; ciphertext and key SHALL be registered on that edge; later input changes are ignored.
REQ-013 in_ready SHALL be 1 only in IDLE.
REQ-014 FSM states: IDLE, KEYEXP, INIT, ROUND, FINAL, DONE.
REQ-015 IDLE -> KEYEXP on input transfer; round counter loaded to 1.
REQ-016 KEYEXP: 10 cycles, each applying the forward key schedule (RotWord, SubWord, Rcon[i]) to the single working key register; after the 10th cycle the register holds round key 10 -> INIT.
REQ-017 INIT: 1 cycle, state <= registered ciphertext XOR round key 10; working key stepped back to round key 9 -> ROUND.
REQ-018 ROUND: 9 cycles (round 9 down to 1), each state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk_i)); working key stepped back one round per cycle -> FINAL after round 1.
REQ-019 Inverse key step: w3=w3'^w2', w2=w2'^w1', w1=w1'^w0', w0=w0'^SubWord(RotWord(new w3))^Rcon[i+1]; Rcon = 01,02,04,08,10,20,40,80,1b,36.
REQ-020 FINAL: 1 cycle, state <= AddRoundKey(InvSubBytes(InvShiftRows(state)), rk0) -> DONE.
REQ-021 Latency: out_valid SHALL first be 1 after the 21st rising edge following the acceptance edge; no overlap of blocks.
REQ-022 DONE: out_valid=1, plaintext stable; DONE -> IDLE on the edge where out_ready=1; out_ready ignored outside DONE.
REQ-023 If out_ready is already 1 when DONE is entered, transfer occurs on the next edge (out_valid high exactly one cycle).
REQ-024 Key schedule SHALL be recomputed per block; no key retained between blocks.
REQ-025 InvSubBytes via 16 aes_inv_sbox instances; SubWord via 4 aes_sbox instances; both combinational.
REQ-026 InvMixColumns SHALL use GF(2^8) multiplies by 09,0b,0d,0e modulo x^8+x^4+x^3+x+1.
REQ-027 plaintext SHALL be driven only from the state register and SHALL not change while out_valid=1.

Reset
REQ-028 On rst=1 at a rising edge: state -> IDLE, out_valid=0, in_ready=1 after that edge, plaintext=0, round counter=0, key/state registers=0.
REQ-029 rst SHALL take priority over all handshakes; reset mid-operation (any state) aborts the block with no output.
REQ-030 in_valid asserted during rst SHALL not be accepted.

Verification
REQ-031 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff, out_valid at edge 21 after acceptance.
REQ-032 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> plaintext 3243f6a8885a308d313198a2e0370734.
REQ-033 Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid and plaintext held constant, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-034 Input hold: change ciphertext/key one cycle after acceptance -> result still matches the accepted C.1 vector.
REQ-035 Reset mid-op: rst=1 for one cycle during ROUND -> out_valid=0, in_ready=1 next cycle; a subsequent App. B block decrypts correctly.
REQ-036 Round-trip: 100 random key/plaintext pairs through aes_main then aes_inv_main -> plaintext equals original every time.
